// File: rtl/stack_motion_ctrl_pkg.sv
// Shared types and constants for the stacker motion controller.
// The saturating speed step is only referenced when SPEED_RAMP_EN is defined.
package stacker_pkg;

  localparam int unsigned COL_W = 4;
  localparam int unsigned ROW_W = 4;
  localparam int unsigned SPD_W = 4;

  localparam int unsigned NUM_COLS_DEF = 10;
  localparam int unsigned NUM_ROWS_DEF = 12;

  localparam logic [SPD_W-1:0] SPD_INIT_DEF = 4'd8;
  localparam logic [SPD_W-1:0] SPD_MIN      = 4'd1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_DRAW       = 4'd1,
    S_DRAW_WAIT  = 4'd2,
    S_HOLD       = 4'd3,
    S_ERASE      = 4'd4,
    S_ERASE_WAIT = 4'd5,
    S_MOVE       = 4'd6,
    S_PLACE      = 4'd7,
    S_OVER       = 4'd8
  } state_t;

  // One step faster, never below SPD_MIN.
  function automatic logic [SPD_W-1:0] spd_ramp(input logic [SPD_W-1:0] cur);
    return (cur > SPD_MIN) ? cur - SPD_W'(1) : SPD_MIN;
  endfunction

endpackage

// File: rtl/stack_motion_ctrl_if.sv
// Plotter handshake between the motion controller (master) and the VGA plotter (slave).
interface stack_motion_ctrl_if;
  import stacker_pkg::*;

  logic             plot_req;
  logic             plot_erase;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             plot_done;

  modport master (output plot_req, plot_erase, col, row, input plot_done);
  modport slave  (input plot_req, plot_erase, col, row, output plot_done);

endinterface

// File: rtl/stack_motion_ctrl_frame_hold_cnt.sv
// Frame tick counter for the HOLD phase; hit fires on the tick that finds cnt == limit.
module frame_hold_cnt
  import stacker_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             tick,
  input  logic [SPD_W-1:0] limit,
  output logic             hit
);

  logic [SPD_W-1:0] cnt_q;

  assign hit = tick && (cnt_q == limit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + SPD_W'(1);
    end
  end

endmodule

// File: rtl/stack_motion_ctrl.sv
// Moving-row sequencer for the stacker game: draw, hold, erase, step, and commit on place.
// Optional `define SPEED_RAMP_EN shortens the hold by one frame per committed block.
module stack_motion_ctrl
  import stacker_pkg::*;
#(
  parameter int unsigned      NUM_COLS = NUM_COLS_DEF,
  parameter int unsigned      NUM_ROWS = NUM_ROWS_DEF,
  parameter logic [SPD_W-1:0] SPD_INIT = SPD_INIT_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic                frame_tick,
  input  logic                place,
  stack_motion_ctrl_if.master plot,
  output logic                dir,
  output logic [SPD_W-1:0]    speed_count,
  output logic                placed_pulse,
  output logic                game_over
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  state_t           state_q;
  logic             req_q;
  logic             erase_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             dir_q;
  logic [SPD_W-1:0] spd_q;
  logic             placed_q;
  logic             over_q;
  logic             pend_q;

  logic hold_clr;
  logic hold_tick;
  logic hold_hit;

  assign hold_tick = frame_tick && (state_q == S_HOLD);
  assign hold_clr  = (state_q != S_HOLD) || hold_hit;

  frame_hold_cnt u_hold (
    .clk    (clk),
    .resetn (resetn),
    .clr    (hold_clr),
    .tick   (hold_tick),
    .limit  (spd_q),
    .hit    (hold_hit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      erase_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      dir_q    <= 1'b0;
      spd_q    <= SPD_INIT;
      placed_q <= 1'b0;
      over_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      placed_q <= 1'b0;
      // A drop outside HOLD is remembered and taken on the next HOLD cycle.
      if (place && !(state_q inside {S_IDLE, S_OVER, S_HOLD})) begin
        pend_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (go) begin
            col_q   <= '0;
            row_q   <= '0;
            dir_q   <= 1'b0;
            spd_q   <= SPD_INIT;
            over_q  <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          req_q   <= 1'b1;
          erase_q <= 1'b0;
          state_q <= S_DRAW_WAIT;
        end
        S_DRAW_WAIT: begin
          if (plot.plot_done) begin
            req_q   <= 1'b0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (place || pend_q) begin
            pend_q   <= 1'b0;
            placed_q <= 1'b1;
            state_q  <= S_PLACE;
          end else if (hold_hit) begin
            state_q <= S_ERASE;
          end
        end
        S_ERASE: begin
          req_q   <= 1'b1;
          erase_q <= 1'b1;
          state_q <= S_ERASE_WAIT;
        end
        S_ERASE_WAIT: begin
          if (plot.plot_done) begin
            req_q   <= 1'b0;
            state_q <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (!dir_q && (col_q == COL_LAST)) begin
            dir_q <= 1'b1;
            col_q <= col_q - COL_W'(1);
          end else if (dir_q && (col_q == '0)) begin
            dir_q <= 1'b0;
            col_q <= col_q + COL_W'(1);
          end else if (dir_q) begin
            col_q <= col_q - COL_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
          state_q <= S_DRAW;
        end
        S_PLACE: begin
`ifdef SPEED_RAMP_EN
          spd_q <= spd_ramp(spd_q);
`else
          spd_q <= spd_q;
`endif
          if (row_q == ROW_LAST) begin
            over_q  <= 1'b1;
            state_q <= S_OVER;
          end else begin
            row_q   <= row_q + ROW_W'(1);
            col_q   <= '0;
            dir_q   <= 1'b0;
            state_q <= S_DRAW;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign plot.plot_req   = req_q;
  assign plot.plot_erase = erase_q;
  assign plot.col        = col_q;
  assign plot.row        = row_q;
  assign dir             = dir_q;
  assign speed_count     = spd_q;
  assign placed_pulse    = placed_q;
  assign game_over       = over_q;

endmodule
